id_ex_stage: RTL
================

# id_ex_stage

ID/EX pipeline register plus execute-stage operand selection for the pipelined RISC-V core. Captures decoded operands, immediate, PC and control from the decode stage each cycle. Drives the ALU's `inp1`, `inp2` and `ALU_control` with EX/MEM and MEM/WB forwarding applied. Also detects load-use hazards and inserts bubbles, with flush and hold support.

## Interface

- `CTRL_W`, 8: width of the opaque pass-through control bundle (reg_write, mem_read, mem_write, result_src, branch, jump, ...).
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `id_valid` input 1: decode stage holds a real instruction.
- `id_pc` input 32: PC of the decode-stage instruction.
- `id_rs1_data` input 32: register-file read data, port 1.
- `id_rs2_data` input 32: register-file read data, port 2.
- `id_imm` input 32: sign-extended immediate.
- `id_rs1`, `id_rs2`, `id_rd` input 5 each: register indices.
- `id_alu_control` input 3: ALU op (000 ADD, 001 SUB, 010 AND, 011 OR, 101 SLT).
- `id_alu_src_a` input 2: operand-A source (00 rs1, 01 PC, 10 zero, 11 zero).
- `id_alu_src_b` input 1: operand-B source (0 rs2, 1 imm).
- `id_mem_read` input 1: decode-stage instruction is a load.
- `id_ctrl` input CTRL_W: pass-through control bundle.
- `flush` input 1: kill the incoming instruction (taken branch/jump).
- `hold` input 1: freeze the stage (downstream stall).
- `ex_mem_reg_write` input 1: EX/MEM instruction writes a register.
- `ex_mem_rd` input 5: EX/MEM destination register.
- `ex_mem_result` input 32: EX/MEM result, forwarding source.
- `mem_wb_reg_write` input 1: MEM/WB instruction writes a register.
- `mem_wb_rd` input 5: MEM/WB destination register.
- `mem_wb_result` input 32: MEM/WB writeback value, forwarding source.
- `alu_inp1`, `alu_inp2` output 32: ALU operands.
- `alu_control` output 3: ALU op.
- `ex_valid` output 1: EX stage holds a real instruction.
- `ex_pc`, `ex_imm` output 32: registered PC and immediate.
- `ex_store_data` output 32: forwarded rs2 value for stores.
- `ex_rd` output 5: EX destination register.
- `ex_mem_read` output 1: EX instruction is a load.
- `ex_ctrl` output CTRL_W: registered control bundle.
- `load_use_stall` output 1: request to freeze PC and IF/ID this cycle.

## Operation

- Registered state: valid, pc, rs1_data, rs2_data, imm, rs1, rs2, rd, alu_control, alu_src_a, alu_src_b, mem_read, ctrl.
- Update on each rising edge of `clk`, priority highest first:
  - `flush` → load a bubble.
  - `hold` → keep all registers unchanged.
  - `load_use_stall` → load a bubble.
  - Otherwise → load the `id_*` inputs.
- Bubble contents: valid=0, ctrl=0, mem_read=0, rd=0, rs1=rs2=0, alu_control=000, src selects 0, data fields 0.
- `load_use_stall` (combinational) = `ex_valid & ex_mem_read & id_valid & ex_rd!=0 & (ex_rd==id_rs1 | ex_rd==id_rs2)`.
  - Match is on indices only; it does not qualify on whether the ID instruction actually reads rs2.
- Forwarding, computed separately for rs1 and rs2 (combinational, on registered indices):
  - If `ex_mem_reg_write`, `ex_mem_rd!=0` and `ex_mem_rd==rsX` → `ex_mem_result`.
  - Else if `mem_wb_reg_write`, `mem_wb_rd!=0` and `mem_wb_rd==rsX` → `mem_wb_result`.
  - Else → registered rsX_data.
  - x0 is never forwarded. EX/MEM wins when both sources match.
- `alu_inp1`: src_a 00 → forwarded rs1; 01 → ex_pc; 1x → 0.
- `alu_inp2`: src_b 0 → forwarded rs2; 1 → ex_imm.
- `ex_store_data` is always the forwarded rs2, regardless of src_b.
- `alu_control` is the registered op, passed through unmodified. All datapaths are 32-bit with no width conversion.

## Timing

- Reset (`rst_n`=0, asynchronous): all registers take bubble contents immediately.
  - Outputs during reset: ex_valid=0, alu_inp1=alu_inp2=0, alu_control=000, ex_store_data=0, load_use_stall=0, ex_ctrl=0.
- Latency: `id_*` inputs appear at the EX outputs one cycle after capture.
- Forwarding is a zero-cycle combinational path; forwarding inputs affect ALU operands within the same cycle.
- Load-use: stall is asserted for exactly one cycle. The bubble enters EX on that edge, the load advances to MEM, and the next edge captures the held ID instruction with MEM/WB forwarding.
- `hold` while `load_use_stall`=1: no bubble; the stall stays asserted until hold drops.
- `flush` together with `hold`: flush wins.
- `rst_n` deasserted mid-operation: resumes with bubbles, no spurious `ex_valid`.

## Test plan

- Reset release, then capture `add x3,x1,x2` with rs1_data=5, rs2_data=7, op=000 → next cycle alu_inp1=5, alu_inp2=7, ex_valid=1, ex_rd=3.
- EX: rs1=3. ex_mem_rd=3, reg_write=1, result=0x100. mem_wb_rd=3, result=0x200 → alu_inp1=0x100. Drop EX/MEM reg_write → alu_inp1=0x200.
- ex_mem_rd=0 with reg_write=1, result=0xFFFF, and EX rs1=0 with rs1_data=0 → alu_inp1=0 (x0 never forwarded).
- EX holds a load with rd=5; ID id_rs2=5, id_valid=1 → load_use_stall=1. Next cycle: ex_valid=0, alu_control=000, stall=0.
- flush and hold both asserted with a valid ID instruction → next cycle ex_valid=0, ex_ctrl=0.
- src_a=01, src_b=1, ex_pc=0x40, imm=0x10 → alu_inp1=0x40, alu_inp2=0x10, while ex_store_data still shows the forwarded rs2 value.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with execute-stage operand muxing, EX/MEM and MEM/WB
// forwarding, and load-use hazard detection (flush > hold > stall bubble > capture).
module id_ex_stage #(
  parameter int CTRL_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [31:0]       id_pc,
  input  logic [31:0]       id_rs1_data,
  input  logic [31:0]       id_rs2_data,
  input  logic [31:0]       id_imm,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic [4:0]        id_rd,
  input  logic [2:0]        id_alu_control,
  input  logic [1:0]        id_alu_src_a,
  input  logic              id_alu_src_b,
  input  logic              id_mem_read,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              flush,
  input  logic              hold,
  input  logic              ex_mem_reg_write,
  input  logic [4:0]        ex_mem_rd,
  input  logic [31:0]       ex_mem_result,
  input  logic              mem_wb_reg_write,
  input  logic [4:0]        mem_wb_rd,
  input  logic [31:0]       mem_wb_result,
  output logic [31:0]       alu_inp1,
  output logic [31:0]       alu_inp2,
  output logic [2:0]        alu_control,
  output logic              ex_valid,
  output logic [31:0]       ex_pc,
  output logic [31:0]       ex_imm,
  output logic [31:0]       ex_store_data,
  output logic [4:0]        ex_rd,
  output logic              ex_mem_read,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic              load_use_stall
);

  localparam int DATA_W = 32;

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] rs1_data;
    logic [DATA_W-1:0] rs2_data;
    logic [DATA_W-1:0] imm;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [4:0]        rd;
    logic [2:0]        alu_control;
    logic [1:0]        alu_src_a;
    logic              alu_src_b;
    logic              mem_read;
    logic [CTRL_W-1:0] ctrl;
  } ex_state_t;

  ex_state_t ex_q, ex_d;
  logic [DATA_W-1:0] rs1_fwd, rs2_fwd;

  // EX/MEM has the younger result, so it takes priority; x0 is never forwarded.
  function automatic logic [DATA_W-1:0] fwd_sel(
    input logic [4:0]        rs,
    input logic [DATA_W-1:0] reg_data,
    input logic              em_we,
    input logic [4:0]        em_rd,
    input logic [DATA_W-1:0] em_res,
    input logic              mw_we,
    input logic [4:0]        mw_rd,
    input logic [DATA_W-1:0] mw_res
  );
    if (em_we && (em_rd != 5'd0) && (em_rd == rs))
      return em_res;
    else if (mw_we && (mw_rd != 5'd0) && (mw_rd == rs))
      return mw_res;
    else
      return reg_data;
  endfunction

  assign load_use_stall = ex_q.valid & ex_q.mem_read & id_valid & (ex_q.rd != 5'd0) &
                          ((ex_q.rd == id_rs1) | (ex_q.rd == id_rs2));

  always_comb begin
    ex_d = ex_q;
    if (flush) begin
      ex_d = '0;
    end else if (hold) begin
      ex_d = ex_q;
    end else if (load_use_stall) begin
      ex_d = '0;
    end else begin
      ex_d.valid       = id_valid;
      ex_d.pc          = id_pc;
      ex_d.rs1_data    = id_rs1_data;
      ex_d.rs2_data    = id_rs2_data;
      ex_d.imm         = id_imm;
      ex_d.rs1         = id_rs1;
      ex_d.rs2         = id_rs2;
      ex_d.rd          = id_rd;
      ex_d.alu_control = id_alu_control;
      ex_d.alu_src_a   = id_alu_src_a;
      ex_d.alu_src_b   = id_alu_src_b;
      ex_d.mem_read    = id_mem_read;
      ex_d.ctrl        = id_ctrl;
    end
  end

  // ID -> EX register boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ex_q <= '0;
    else        ex_q <= ex_d;
  end

  always_comb begin
    rs1_fwd = fwd_sel(ex_q.rs1, ex_q.rs1_data, ex_mem_reg_write, ex_mem_rd, ex_mem_result,
                      mem_wb_reg_write, mem_wb_rd, mem_wb_result);
    rs2_fwd = fwd_sel(ex_q.rs2, ex_q.rs2_data, ex_mem_reg_write, ex_mem_rd, ex_mem_result,
                      mem_wb_reg_write, mem_wb_rd, mem_wb_result);
  end

  always_comb begin
    alu_inp1 = '0;
    case (ex_q.alu_src_a)
      2'b00:   alu_inp1 = rs1_fwd;
      2'b01:   alu_inp1 = ex_q.pc;
      default: alu_inp1 = '0;
    endcase
  end

  assign alu_inp2      = ex_q.alu_src_b ? ex_q.imm : rs2_fwd;
  assign ex_store_data = rs2_fwd;
  assign alu_control   = ex_q.alu_control;
  assign ex_valid      = ex_q.valid;
  assign ex_pc         = ex_q.pc;
  assign ex_imm        = ex_q.imm;
  assign ex_rd         = ex_q.rd;
  assign ex_mem_read   = ex_q.mem_read;
  assign ex_ctrl       = ex_q.ctrl;

endmodule
